// File: rtl/ccff_chain_loader_pkg.sv
// ccff_loader_pkg: shared types and constants for the configuration-chain loader.
//   - ccff_state_e : loader FSM states (IDLE, LOAD, SHIFT, DONE)
//   - CRC16_POLY / CRC16_INIT : CRC-16-CCITT constants for the optional readback CRC
//   - crc16_next   : one serial MSB-first CRC-16 update step
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit of a serial CRC-16: feedback is the outgoing MSB xor the new bit.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb_s;
    fb_s       = crc[15] ^ din;
    crc16_next = {crc[14:0], 1'b0} ^ (fb_s ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready word stream feeding the chain loader.
//   s_valid : producer has a word
//   s_ready : loader can accept a word
//   s_data  : configuration word, bit 0 is shifted onto the chain first
// Modports: master (producer side), slave (loader side).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ccff_chain_loader_crc16.sv
// ccff_crc16: serial CRC-16-CCITT register (poly 0x1021, init 0xFFFF, MSB-first,
// no final xor). Only built when CCFF_READBACK_CRC_EN is defined.
//   CK   : clock
//   RN   : asynchronous active-low reset (crc -> 0xFFFF)
//   init : reload 0xFFFF (wins over en)
//   en   : fold din into the CRC this cycle
//   din  : serial input bit
//   crc  : registered CRC value
`ifdef CCFF_READBACK_CRC_EN
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        CK,
  input  logic        RN,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_r;
  logic [15:0] crc_s;

  // Next CRC value: reload, update or hold.
  always_comb begin
    crc_s = crc_r;
    if (init) begin
      crc_s = CRC16_INIT;
    end else if (en) begin
      crc_s = crc16_next(crc_r, din);
    end else begin
      crc_s = crc_r;
    end
  end

  // CRC state register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      crc_r <= CRC16_INIT;
    end else begin
      crc_r <= crc_s;
    end
  end

  assign crc = crc_r;

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words LSB-first onto a chain of
// CHAIN_LEN configuration flops and pulses done after exactly CHAIN_LEN bits.
// Optional feature macro: CCFF_READBACK_CRC_EN adds readback_crc, a CRC-16 of
// the previous chain contents as they leave through ccff_tail.
// Ports:
//   CK, RN     : clock (rising edge), asynchronous active-low reset
//   start      : begin a load (only acted on in IDLE)
//   abort      : abandon a load in progress, back to IDLE next cycle
//   s          : word stream (slave side of ccff_chain_loader_if)
//   ccff_head  : registered serial data into the chain
//   ccff_en    : registered chain shift enable
//   ccff_tail  : serial data out of the chain
//   busy       : high in LOAD and SHIFT
//   done       : one-cycle pulse after the final chain bit
//   readback_crc (CCFF_READBACK_CRC_EN only) : CRC of bits seen on ccff_tail
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 abort,
  ccff_chain_loader_if.slave   s,
  output logic                 ccff_head,
  output logic                 ccff_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done
`ifdef CCFF_READBACK_CRC_EN
  ,
  output logic [15:0]          readback_crc
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  ccff_state_e       state_r, state_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic [IDX_W-1:0]  bit_idx_r, bit_idx_s;
  logic [WORD_W-1:0] shreg_r, shreg_s;
  logic              head_r, head_s;
  logic              en_r, en_s;
  logic              done_r, done_s;
  logic              busy_r, busy_s;
  logic              ready_s;
  logic              hs_s;
  logic              word_last_s;
  logic              chain_last_s;

  // bit_cnt_r counts bits already emitted; bit_idx_r is the word bit shown now.
  assign word_last_s  = (bit_idx_r == LAST_IDX);
  assign chain_last_s = (bit_cnt_r == LAST_CNT);

  // Ready in LOAD, or on the last bit of a word when the chain still needs more.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == LOAD) begin
      ready_s = 1'b1;
    end else if ((state_r == SHIFT) && word_last_s && !chain_last_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign s.s_ready = ready_s;
  assign hs_s      = s.s_valid && ready_s;

  // FSM next state and next register values; abort outranks any handshake.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    bit_idx_s = bit_idx_r;
    shreg_s   = shreg_r;
    head_s    = 1'b0;
    en_s      = 1'b0;
    done_s    = 1'b0;
    if (abort && (state_r != IDLE)) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s   = LOAD;
            bit_cnt_s = {CNT_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          if (hs_s) begin
            // Bit 0 goes straight to the head register, the rest waits in shreg.
            head_s    = s.s_data[0];
            shreg_s   = {1'b0, s.s_data[WORD_W-1:1]};
            bit_idx_s = {IDX_W{1'b0}};
            en_s      = 1'b1;
            state_s   = SHIFT;
          end else begin
            state_s = LOAD;
          end
        end
        SHIFT: begin
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
          if (chain_last_s) begin
            // Leftover word bits are dropped.
            state_s = DONE;
            done_s  = 1'b1;
          end else if (word_last_s) begin
            if (hs_s) begin
              head_s    = s.s_data[0];
              shreg_s   = {1'b0, s.s_data[WORD_W-1:1]};
              bit_idx_s = {IDX_W{1'b0}};
              en_s      = 1'b1;
              state_s   = SHIFT;
            end else begin
              state_s = LOAD;
            end
          end else begin
            head_s    = shreg_r[0];
            shreg_s   = {1'b0, shreg_r[WORD_W-1:1]};
            bit_idx_s = bit_idx_r + IDX_W'(1);
            en_s      = 1'b1;
            state_s   = SHIFT;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    busy_s = (state_s == LOAD) || (state_s == SHIFT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_r   <= IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r <= {IDX_W{1'b0}};
      shreg_r   <= {WORD_W{1'b0}};
      head_r    <= 1'b0;
      en_r      <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      bit_idx_r <= bit_idx_s;
      shreg_r   <= shreg_s;
      head_r    <= head_s;
      en_r      <= en_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
    end
  end

  assign ccff_head = head_r;
  assign ccff_en   = en_r;
  assign done      = done_r;
  assign busy      = busy_r;

`ifdef CCFF_READBACK_CRC_EN
  logic crc_init_s;

  assign crc_init_s = (state_r == IDLE) && start;

  ccff_crc16 u_crc (
    .CK   (CK),
    .RN   (RN),
    .init (crc_init_s),
    .en   (en_r),
    .din  (ccff_tail),
    .crc  (readback_crc)
  );
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized scoreboard bench for ccff_chain_loader.
// The driver pushes the expected head bits of every accepted word (trimmed to
// what the chain still needs) into a queue; a negedge monitor pops one bit per
// ccff_en cycle and checks done, bit counts and (with CCFF_READBACK_CRC_EN) the CRC.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int WORDS_PER_LOAD = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ccff_head, ccff_en, ccff_tail, busy, done;
  logic [CHAIN_LEN-1:0] chain_m = '0;
`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] readback_crc;
`endif

  ccff_chain_loader_if #(.WORD_W(WORD_W)) sif ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .CK        (CK),
    .RN        (RN),
    .start     (start),
    .abort     (abort),
    .s         (sif),
    .ccff_head (ccff_head),
    .ccff_en   (ccff_en),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done)
`ifdef CCFF_READBACK_CRC_EN
    ,
    .readback_crc (readback_crc)
`endif
  );

  always #5 CK = ~CK;

  // Behavioural configuration chain: head enters flop 0, tail leaves the last flop.
  always @(posedge CK) begin
    if (ccff_en) chain_m <= {chain_m[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain_m[CHAIN_LEN-1];

  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  bit tail_q[$];
  logic [WORD_W-1:0] fix_q[$];
  int dones_seen = 0;
  int mon_en_cnt = 0;
  bit prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC-16-CCITT reference over a list of bits, init 0xFFFF, MSB-first.
  function automatic logic [15:0] crc_ref(input bit q[$]);
    int c;
    c = 32'h0000FFFF;
    foreach (q[i]) begin
      c = c ^ (int'(q[i]) << 15);
      if ((c & 32'h00008000) != 0) c = (c << 1) ^ 32'h00001021;
      else c = c << 1;
      c = c & 32'h0000FFFF;
    end
    return c[15:0];
  endfunction

  // Monitor: consume one expected bit per enabled cycle, validate each done pulse.
  always @(negedge CK) begin
    bit b;
    if (RN) begin
      if (ccff_en) begin
        check("en_implies_busy", busy, 1);
        if (exp_q.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("head_bit", ccff_head, b);
        end
        mon_en_cnt++;
        tail_q.push_back(ccff_tail);
      end
      if (done) begin
        dones_seen++;
        check("en_count_at_done", mon_en_cnt, CHAIN_LEN);
        check("done_after_last_bit", prev_en, 1);
        check("queue_drained", exp_q.size(), 0);
`ifdef CCFF_READBACK_CRC_EN
        check("readback_crc", readback_crc, crc_ref(tail_q));
`endif
      end
      if (!busy && !done) mon_en_cnt = 0;
      prev_en = ccff_en;
    end else begin
      mon_en_cnt = 0;
      prev_en = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, sif.s_ready, 0);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_en"}, ccff_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode 0: complete load; 1: abort after stop_at bits; 2: async reset after stop_at bits.
  task automatic run_load(input int gap_lo, input int gap_hi, input int mode,
                          input int stop_at, input bit spam);
    int to_send = CHAIN_LEN;
    int words = 0;
    int en_seen = 0;
    int first_en = -1;
    int last_en = -1;
    int d0;
    int gap = 0;
    int n;
    bit have = 1'b0;
    bit fin = 1'b0;
    bit busy_ok = 1'b1;
    logic [WORD_W-1:0] w = '0;
    @(posedge CK); #1;
    start = 1'b1;
    tail_q.delete();
    d0 = dones_seen;
    @(posedge CK); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (!have && to_send > 0) begin
        if (gap > 0) gap--;
        else begin
          if (fix_q.size() > 0) w = fix_q.pop_front();
          else w = WORD_W'($urandom);
          have = 1'b1;
        end
      end
      sif.s_valid = have;
      sif.s_data = have ? w : {WORD_W{1'b0}};
      if (spam) start = 1'($urandom_range(1, 0));
      abort = (mode == 1) && (en_seen >= stop_at);
      @(negedge CK);
      if (!busy && !done) busy_ok = 1'b0;
      if (ccff_en) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        en_seen++;
      end
      if (sif.s_valid && sif.s_ready && !abort) begin
        n = (to_send < WORD_W) ? to_send : WORD_W;
        for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
        to_send -= n;
        words++;
        have = 1'b0;
        gap = $urandom_range(gap_hi, gap_lo);
      end
      if (abort) begin
        @(posedge CK); #1;
        abort = 1'b0;
        start = 1'b0;
        sif.s_valid = 1'b0;
        @(negedge CK);
        check("abort_busy", busy, 0);
        check("abort_en", ccff_en, 0);
        check("abort_s_ready", sif.s_ready, 0);
        exp_q.delete();
        repeat (4) @(negedge CK);
        check("abort_no_done", dones_seen, d0);
        fin = 1'b1;
      end else if (mode == 2 && en_seen >= stop_at) begin
        #2 RN = 1'b0;
        #1 check_idle_outputs("async_rst");
        exp_q.delete();
        sif.s_valid = 1'b0;
        @(posedge CK); #1;
        RN = 1'b1;
        fin = 1'b1;
      end else if (done) begin
        @(posedge CK); #1;
        start = 1'b0;
        sif.s_valid = 1'b0;
        check("done_count", dones_seen, d0 + 1);
        check("words_per_load", words, WORDS_PER_LOAD);
        check("busy_during_load", busy_ok, 1);
        if (gap_hi == 0) check("no_gap_span", last_en - first_en + 1, CHAIN_LEN);
        @(negedge CK);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        fin = 1'b1;
      end else begin
        @(posedge CK); #1;
      end
    end
    if (!fin) begin
      check("load_timeout", 0, 1);
      start = 1'b0;
      abort = 1'b0;
      sif.s_valid = 1'b0;
    end
    exp_q.delete();
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = {WORD_W{1'b0}};
    repeat (2) @(posedge CK);
    #1 check_idle_outputs("reset");
    @(negedge CK);
    RN = 1'b1;

    // Basic load: A5, 3C, 0F with valid held; upper nibble of 0F is dropped.
    fix_q = '{8'hA5, 8'h3C, 8'h0F};
    run_load(0, 0, 0, 0, 1'b0);

    // Stall of 5 cycles between words.
    fix_q = '{8'hA5, 8'h3C, 8'h0F};
    run_load(5, 5, 0, 0, 1'b0);

    // Abort after 10 bits, then a fresh load.
    run_load(0, 0, 1, 10, 1'b0);
    run_load(0, 2, 0, 0, 1'b0);

    // Asynchronous reset mid-shift, then a fresh load.
    run_load(0, 0, 2, 6, 1'b0);
    run_load(0, 3, 0, 0, 1'b0);

    // start toggling during LOAD/SHIFT/DONE must not disturb the load.
    run_load(0, 0, 0, 0, 1'b1);

    // Randomized loads with random gaps.
    for (int k = 0; k < 6; k++) run_load(0, 3, 0, 0, 1'($urandom_range(1, 0)));

    repeat (3) @(posedge CK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Parametrised configuration-chain loader for the tileable fabric.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto a chain of CHAIN_LEN DFFRX1-style configuration flops.
- Drives serial head data and a shift enable, counts bits, and pulses done when exactly CHAIN_LEN bits have been shifted.
- Sits between the programming interface and the ccff_head of the fabric's configuration chain.

Parameters:
- CHAIN_LEN, 64: number of configuration flops in the chain; minimum 1.
- WORD_W, 8: input word width in bits; minimum 2.
- CNT_W, $clog2(CHAIN_LEN+1): derived localparam, width of the bit counter. Not overridable.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RN  input  1  asynchronous active-low reset.
- start  input  1  begin a load; honoured only in IDLE.
- abort  input  1  synchronous abort of a load in progress.
- s_valid  input  1  word available.
- s_ready  output  1  loader can accept a word.
- s_data  input  WORD_W  configuration word; bit 0 is shifted first.
- ccff_head  output  1  serial data into the chain.
- ccff_en  output  1  chain shift enable.
- ccff_tail  input  1  serial data out of the chain.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  one-cycle pulse after the final bit.

Interface decisions: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (RN=0), asynchronous: state=IDLE; all outputs 0 (s_ready, ccff_head, ccff_en, busy, done); bit counter, word-bit index and shift register cleared. Reset mid-load discards the load.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD; bit counter = 0.
  - start ignored in all other states.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: capture s_data into the shift register, word-bit index = 0, go to SHIFT.
- SHIFT:
  - ccff_en and ccff_head are registered. A word accepted in cycle N produces bit 0 on ccff_head with ccff_en=1 in cycle N+1.
  - Each SHIFT cycle: emit one bit, shift right, bit counter +1, word-bit index +1.
  - Last bit of the chain (counter reaches CHAIN_LEN): -> DONE. Remaining word bits are discarded. s_ready stays 0.
  - Last bit of the word with chain not complete: s_ready=1 in that cycle.
    - If a word is accepted, stay in SHIFT with no gap. Back-to-back throughput is WORD_W cycles per word.
    - Otherwise -> LOAD. ccff_en drops to 0 and the chain holds its contents.
- DONE: done=1 for exactly one cycle; ccff_en=0; then -> IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle: state=IDLE, ccff_en=0, s_ready=0, no done pulse.
  - abort has priority over a handshake in the same cycle; that word is not consumed.
- s_ready is combinational from state and counters only. It never depends on s_valid.
- ccff_en is never high outside SHIFT.
- busy=1 exactly in LOAD and SHIFT.
- Total ccff_en-high cycles per completed load is exactly CHAIN_LEN.
- Words needed per load: ceil(CHAIN_LEN/WORD_W).

Optional Feature:
- Macro: CCFF_READBACK_CRC_EN.
- Defined:
  - Adds output port readback_crc[15:0].
  - Computes CRC-16-CCITT: polynomial 0x1021, init 0xFFFF, MSB-first update, no final XOR.
  - Input is ccff_tail, sampled on every cycle ccff_en=1, i.e. the previous chain contents as they shift out.
  - CRC re-initialises to 0xFFFF on start acceptance.
  - CRC holds its value after DONE until the next start. Reset value 0xFFFF.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ccff_loader_pkg:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - CRC16_POLY=16'h1021;
  - CRC16_INIT=16'hFFFF.
- Sub-module ccff_crc16: a serial CRC bit-update register with enable and init inputs. Instantiated only under CCFF_READBACK_CRC_EN.

Test Plan:
- Basic load, CHAIN_LEN=20, WORD_W=8: start, then words 0xA5, 0x3C, 0x0F (s_valid held). Head stream = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. ccff_en high for exactly 20 cycles with no gaps. done pulses one cycle after the 20th bit. Upper nibble of 0x0F discarded.
- Stall: same config, s_valid dropped for 5 cycles after the first word. ccff_en=0 during the stall, then resumes. Total ccff_en-high count = 20.
- Abort: abort asserted after 10 shifted bits. Next cycle IDLE, busy=0, ccff_en=0, no done pulse. A fresh start completes normally.
- Async reset: RN pulsed low mid-SHIFT between clock edges. All outputs 0 immediately, state IDLE.
- start during SHIFT and DONE: ignored; bit count unaffected.
- CRC (macro on), CHAIN_LEN=16, WORD_W=8: ccff_tail driven from a 16-bit model chain preloaded with 0x0000. Load any data; readback_crc = CRC-16-CCITT of 16 zero bits from init 0xFFFF, checked against the model.
